// File: rtl/vec_adder_pipe.sv
// vec_adder_pipe
// Pipelined SIMD adder for the vector integer ALU. The WIDTH-bit operands are
// split into independent 8/16/32/64-bit elements (sew) and each element gets
// ADD, SUB (a-b), unsigned saturating add or signed saturating add (op).
// Results leave through a LATENCY-deep valid/ready pipeline that preserves order
// and holds its output steady under backpressure.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand beat handshake (a, b, sew, op captured per beat)
//   out_valid/ out_ready result beat handshake (s, cout, sat)
//   s                    per-element wrapped or clamped result
//   cout                 raw element carry-out, placed in the element's top byte bit
//   sat                  element clamped flag, same placement (0 for ADD/SUB)
//   sat_flag             sticky: set after a retiring beat had any sat bit
//   sat_clr              synchronous clear of sat_flag (a simultaneous set wins)
module vec_adder_pipe #(
   parameter int WIDTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         sew,
   input  logic [1:0]         op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   s,
   output logic [WIDTH/8-1:0] cout,
   output logic [WIDTH/8-1:0] sat,
   output logic               sat_flag,
   input  logic               sat_clr
);

   localparam int NB = WIDTH / 8;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_SADDU = 2'b10;
   localparam logic [1:0] OP_SADD  = 2'b11;

   int               ebytes;
   logic             is_sub;
   logic             carry;
   logic [7:0]       bx;
   logic [8:0]       bsum;
   logic [WIDTH-1:0] raw;
   logic [NB-1:0]    byte_cy;
   logic [NB-1:0]    byte_ovf;

   logic             clamp;
   logic             neg;
   logic [WIDTH-1:0] res_s;
   logic [NB-1:0]    res_c;
   logic [NB-1:0]    res_sat;

   // Byte-serial carry chain; the chain restarts at every element boundary so
   // no carry crosses elements. SUB feeds ~b with cin=1 into each element.
   always_comb begin
      ebytes   = 1 << sew;
      is_sub   = (op == OP_SUB);
      carry    = 1'b0;
      bx       = '0;
      bsum     = '0;
      raw      = '0;
      byte_cy  = '0;
      byte_ovf = '0;
      for (int i = 0; i < NB; i++) begin
         bx = is_sub ? ~b[i*8 +: 8] : b[i*8 +: 8];
         if (i % ebytes == 0) carry = is_sub;
         bsum = {1'b0, a[i*8 +: 8]} + {1'b0, bx} + {8'd0, carry};
         raw[i*8 +: 8] = bsum[7:0];
         byte_cy[i]    = bsum[8];
         carry         = bsum[8];
         // Signed overflow: operands agree in sign but the result does not.
         byte_ovf[i]   = (a[i*8+7] == bx[7]) && (bsum[7] != a[i*8+7]);
      end
   end

   // Walk bytes from the top so each element's clamp decision, made at its
   // most-significant byte, is known when its lower bytes are visited.
   always_comb begin
      clamp   = 1'b0;
      neg     = 1'b0;
      res_s   = raw;
      res_c   = '0;
      res_sat = '0;
      for (int i = NB - 1; i >= 0; i--) begin
         if (i % ebytes == ebytes - 1) begin
            clamp = (op == OP_SADDU) ? byte_cy[i] :
                    (op == OP_SADD)  ? byte_ovf[i] : 1'b0;
            neg        = a[i*8+7];
            res_c[i]   = byte_cy[i];
            res_sat[i] = clamp;
            if (clamp)
               res_s[i*8 +: 8] = (op == OP_SADDU) ? 8'hFF : (neg ? 8'h80 : 8'h7F);
         end else if (clamp) begin
            res_s[i*8 +: 8] = (op == OP_SADDU) ? 8'hFF : (neg ? 8'h00 : 8'hFF);
         end
      end
   end

   logic [LATENCY-1:0] st_v;
   logic [LATENCY-1:0] adv;
   logic [WIDTH-1:0]   st_s   [LATENCY];
   logic [NB-1:0]      st_c   [LATENCY];
   logic [NB-1:0]      st_sat [LATENCY];

   // A stage may load when it is empty or its content moves on this cycle.
   always_comb begin
      adv            = '0;
      adv[LATENCY-1] = !st_v[LATENCY-1] || out_ready;
      for (int k = LATENCY - 2; k >= 0; k--)
         adv[k] = !st_v[k] || adv[k+1];
   end

   assign in_ready = adv[0];

   // Data only loads with a valid beat so the output keeps the last result
   // rather than tracking idle operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            st_v[k]   <= 1'b0;
            st_s[k]   <= '0;
            st_c[k]   <= '0;
            st_sat[k] <= '0;
         end
      end else begin
         if (adv[0]) begin
            st_v[0] <= in_valid;
            if (in_valid) begin
               st_s[0]   <= res_s;
               st_c[0]   <= res_c;
               st_sat[0] <= res_sat;
            end
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (adv[k]) begin
               st_v[k] <= st_v[k-1];
               if (st_v[k-1]) begin
                  st_s[k]   <= st_s[k-1];
                  st_c[k]   <= st_c[k-1];
                  st_sat[k] <= st_sat[k-1];
               end
            end
         end
      end
   end

   assign out_valid = st_v[LATENCY-1];
   assign s         = st_s[LATENCY-1];
   assign cout      = st_c[LATENCY-1];
   assign sat       = st_sat[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sat_flag <= 1'b0;
      else if (out_valid && out_ready && (|sat))
         sat_flag <= 1'b1;
      else if (sat_clr)
         sat_flag <= 1'b0;
   end

endmodule

// File: doc/vec_adder_pipe.md
Name: vec_adder_pipe

Overview:
- Pipelined, SEW-configurable SIMD adder. Successor to the flat combinational n-bit adder.
- Splits a WIDTH-bit datapath into independent elements of 8/16/32/64 bits and performs per-element add, subtract, or saturating add.
- Uses valid/ready handshakes on both sides, a programmable pipeline depth, per-element carry-out and a sticky saturation flag.
- Sits between the vector register-file read port and the writeback arbiter in the V-extension integer ALU.

Parameters:
- WIDTH, 64: datapath width in bits; must be a multiple of 64.
- LATENCY, 2: pipeline register stages, legal range 1..4; fixed latency when unstalled.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sew  in  2  element width: 00=8, 01=16, 10=32, 11=64
- op  in  2  00=ADD, 01=SUB (a-b), 10=SADDU, 11=SADD
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- s  out  WIDTH  per-element result
- cout  out  WIDTH/8  per-byte carry map
- sat  out  WIDTH/8  per-byte saturation map for the current beat
- sat_flag  out  1  sticky saturation flag (vxsat-like)
- sat_clr  in  1  synchronous clear of sat_flag

Behaviour:
- Reset (async, rst=1): all stage valid bits=0, out_valid=0, s=0, cout=0, sat=0, sat_flag=0. in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: every in-flight beat is discarded and no result is emitted after reset.
- Handshake: a beat is accepted when in_valid&&in_ready and retires when out_valid&&out_ready.
- Stage k advances when it is empty or stage k+1 advances; the last stage advances on out_ready.
- in_ready = stage0 empty || stage0 advances (combinational from out_ready is allowed).
- Capacity is LATENCY beats. Unstalled, the result appears exactly LATENCY cycles after acceptance.
- Throughput: 1 beat/cycle. Order is preserved.
- While out_valid=1 and out_ready=0, s/cout/sat hold stable.
- sew and op are captured with the operands per beat; changing them between beats is legal.
- Element arithmetic, element width E = 8<<sew, applied independently per element with no carry across element boundaries:
  - ADD: a+b, cin=0.
  - SUB: a+~b, cin=1. cout=1 means no borrow.
  - SADDU: unsigned add, clamped to all-ones on carry-out.
  - SADD: signed add, clamped to 2^(E-1)-1 on positive overflow and -2^(E-1) on negative overflow.
- s holds the wrapped sum for ADD/SUB and the clamped value for the saturating ops.
- cout map: the element's raw carry-out of the top bit appears in the bit of its most-significant byte; all other bits of that element are 0.
- sat map: same placement, 1 if the element was clamped. Always 0 for ADD/SUB.
- Internal split point: a pipeline may split carry propagation at byte boundaries. The result must be bit-identical to the unpipelined function for every LATENCY.
- sat_flag:
  - Set on the cycle after a retiring beat (out_valid&&out_ready) has any sat bit set.
  - Cleared by sat_clr.
  - Simultaneous set and clear: set wins.
  - Stalled beats do not set it until they retire.

Test Plan:
- ADD, WIDTH=64, LATENCY=2, sew=00, a=0x00000000000000FF, b=0x0000000000000001 -> s=0x0000000000000000, cout=0x01. Same operands with sew=01 -> s=0x0000000000000100, cout=0x00. Each out_valid appears exactly 2 cycles after acceptance.
- SUB, sew=10, a=0x0000000900000005, b=0x0000000400000007 -> s=0x00000005FFFFFFFE, cout=0x80 (upper element no borrow, lower element borrow).
- SADD, sew=00, a byte0=0x7F, b byte0=0x01, a byte1=0x80, b byte1=0xFF, other bytes 0 -> s byte0=0x7F, s byte1=0x80, sat=0x03. sat_flag=1 on the cycle after retirement and stays 1 through later clean beats until sat_clr.
- SADDU, sew=11, a=0xFFFFFFFFFFFFFFF0, b=0x20 -> s=0xFFFFFFFFFFFFFFFF, sat=0x80, cout=0x80. A non-overflowing SADDU beat gives sat=0x00.
- Backpressure: LATENCY=2, out_ready=0, 3 back-to-back beats -> the first 2 are accepted, then in_ready=0 and s holds the first result. After out_ready=1, results retire in order on consecutive cycles and the third beat is accepted the same cycle the first retires.
- Assert rst with 2 beats in flight -> outputs are zero immediately (asynchronous), sat_flag=0, and no stale beat appears after release. Driving sat_clr on the same cycle a saturated beat retires leaves sat_flag=1.
